// File: rtl/handshake_constant_rep.sv
// handshake_constant_rep
// Elastic constant source: every accepted ctrl token is expanded into a burst
// of REPEAT output tokens carrying VALUE, with outs_last marking the final
// token of each burst. Outputs come straight from registers, so the valid path
// from upstream is broken. Backpressure is honoured: data is held while
// outs_valid is high and outs_ready is low.
//
// Optional feature, enabled by defining HANDSHAKE_CONSTANT_STEP_EN:
//   repetition k of a burst carries (VALUE + k*STEP) mod 2^DATA_WIDTH. The
//   value is built incrementally with a DATA_WIDTH-wide adder that wraps
//   silently. Without the macro every token carries VALUE, STEP is ignored
//   and no adder exists.
module handshake_constant_rep #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] VALUE      = '0,
   parameter int                    REPEAT     = 1,
   parameter logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_last
);

   // A REPEAT of 0 is treated as a single-token burst.
   localparam int REP_EFF = (REPEAT < 1) ? 1 : REPEAT;
   localparam int CNT_W   = (REP_EFF <= 2) ? 1 : $clog2(REP_EFF);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(REP_EFF - 1);
   localparam logic FIRST_IS_LAST = (REP_EFF == 1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic [DATA_WIDTH-1:0] outs_q, outs_d;
   logic                  last_q, last_d;
   logic                  ctrl_fire;
   logic                  outs_fire;
   logic [DATA_WIDTH-1:0] outs_next_rep;

   // outs_valid is the registered state itself, so nothing combinational
   // reaches it from the inputs.
   assign outs_valid = (state_q == EMIT);
   assign outs       = outs_q;
   assign outs_last  = last_q;

   // A new trigger is taken when idle, or when the final token of the current
   // burst leaves this cycle; this gives back-to-back bursts with no bubble.
   // Deliberately independent of ctrl_valid.
   assign ctrl_ready = !outs_valid || (outs_ready && last_q);

   assign ctrl_fire = ctrl_valid && ctrl_ready;
   assign outs_fire = outs_valid && outs_ready;
   assign cnt_inc   = cnt_q + 1'b1;

`ifdef HANDSHAKE_CONSTANT_STEP_EN
   // Next repetition value: wraps modulo 2^DATA_WIDTH, carry discarded.
   assign outs_next_rep = outs_q + STEP;
`else
   // Every repetition repeats the constant; STEP plays no part.
   assign outs_next_rep = outs_q;
`endif

   // Next-state, repetition counter and output data selection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      outs_d  = outs_q;
      last_d  = last_q;
      if (ctrl_fire) begin
         // Start of a burst (from IDLE, or chained onto a finishing burst).
         state_d = EMIT;
         cnt_d   = '0;
         outs_d  = VALUE;
         last_d  = FIRST_IS_LAST;
      end else if (outs_fire) begin
         if (last_q) begin
            // Burst finished with no new trigger: outs keeps its last value.
            state_d = IDLE;
            last_d  = 1'b0;
         end else begin
            // Advance to the next repetition; the counter stops at LAST_IDX.
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == LAST_IDX);
            outs_d = outs_next_rep;
         end
      end
   end

   // State, counter and output registers; reset abandons any burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         outs_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         outs_q  <= outs_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_handshake_constant_rep.sv
// Bench for handshake_constant_rep: five instances with different widths,
// constants, steps and repeat counts, each compared cycle by cycle against a
// queue of expected tokens filled whenever a trigger is accepted.
module tb_handshake_constant_rep;

   localparam int N = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        cv     [N];
   logic        ordy   [N];
   logic [31:0] obs_d  [N];
   logic        obs_v  [N];
   logic        obs_l  [N];
   logic        obs_cr [N];

   logic [20:0] o0;
   logic [7:0]  o1;
   logic [7:0]  o2;
   logic [11:0] o3;
   logic [15:0] o4;

   typedef logic [32:0] tok_t;   // {last, data}
   tok_t        q       [N][$];
   logic [31:0] lastval [N];
   int          ntok    [N];
   int          checks;
   int          errors;

   always #5 clk = ~clk;

   handshake_constant_rep #(.DATA_WIDTH(21), .VALUE(21'h082D01), .REPEAT(1), .STEP(21'd1)) u_i0 (
      .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(obs_cr[0]),
      .outs(o0), .outs_valid(obs_v[0]), .outs_ready(ordy[0]), .outs_last(obs_l[0]));
   handshake_constant_rep #(.DATA_WIDTH(8), .VALUE(8'hFE), .REPEAT(4), .STEP(8'd1)) u_i1 (
      .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(obs_cr[1]),
      .outs(o1), .outs_valid(obs_v[1]), .outs_ready(ordy[1]), .outs_last(obs_l[1]));
   handshake_constant_rep #(.DATA_WIDTH(8), .VALUE(8'h07), .REPEAT(4), .STEP(8'd3)) u_i2 (
      .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(obs_cr[2]),
      .outs(o2), .outs_valid(obs_v[2]), .outs_ready(ordy[2]), .outs_last(obs_l[2]));
   handshake_constant_rep #(.DATA_WIDTH(12), .VALUE(12'hABC), .REPEAT(3), .STEP(12'h100)) u_i3 (
      .clk(clk), .rst(rst), .ctrl_valid(cv[3]), .ctrl_ready(obs_cr[3]),
      .outs(o3), .outs_valid(obs_v[3]), .outs_ready(ordy[3]), .outs_last(obs_l[3]));
   handshake_constant_rep #(.DATA_WIDTH(16), .VALUE(16'hFFFD), .REPEAT(5), .STEP(16'd2)) u_i4 (
      .clk(clk), .rst(rst), .ctrl_valid(cv[4]), .ctrl_ready(obs_cr[4]),
      .outs(o4), .outs_valid(obs_v[4]), .outs_ready(ordy[4]), .outs_last(obs_l[4]));

   assign obs_d[0] = {11'b0, o0};
   assign obs_d[1] = {24'b0, o1};
   assign obs_d[2] = {24'b0, o2};
   assign obs_d[3] = {20'b0, o3};
   assign obs_d[4] = {16'b0, o4};

   // Instance configuration as seen by the reference model.
   function automatic int wid(input int i);
      case (i)
         0:       return 21;
         1:       return 8;
         2:       return 8;
         3:       return 12;
         default: return 16;
      endcase
   endfunction

   function automatic logic [31:0] val(input int i);
      case (i)
         0:       return 32'h082D01;
         1:       return 32'hFE;
         2:       return 32'h07;
         3:       return 32'hABC;
         default: return 32'hFFFD;
      endcase
   endfunction

   function automatic logic [31:0] stp(input int i);
      case (i)
         0:       return 32'd1;
         1:       return 32'd1;
         2:       return 32'd3;
         3:       return 32'h100;
         default: return 32'd2;
      endcase
   endfunction

   function automatic int rep(input int i);
      case (i)
         0:       return 1;
         1:       return 4;
         2:       return 4;
         3:       return 3;
         default: return 5;
      endcase
   endfunction

   // Value carried by repetition k of a burst on instance i.
   function automatic logic [31:0] exp_data(input int i, input int k);
      logic [31:0] m;
      m = (32'h1 << wid(i)) - 32'h1;
`ifdef HANDSHAKE_CONSTANT_STEP_EN
      return (val(i) + 32'(k) * stp(i)) & m;
`else
      if (k < 0) return 32'h0;
      return val(i) & m;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: check ctrl_ready before the edge, advance the model on
   // the edge, then check the registered outputs after it.
   task automatic step();
      bit fo [N];
      bit fc [N];
      bit er;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         er = (q[i].size() == 0) || (q[i].size() == 1 && ordy[i]);
         check($sformatf("i%0d_ctrl_ready", i), {31'b0, obs_cr[i]}, {31'b0, er});
         fo[i] = (q[i].size() > 0) && ordy[i];
         fc[i] = cv[i] && er;
         if (obs_v[i] === 1'b1 && ordy[i]) ntok[i]++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            q[i].delete();
            lastval[i] = '0;
         end else begin
            if (fo[i]) lastval[i] = q[i].pop_front() & 33'hFFFFFFFF;
            if (fc[i])
               for (int k = 0; k < rep(i); k++)
                  q[i].push_back({(k == rep(i) - 1), exp_data(i, k)});
         end
         check($sformatf("i%0d_valid", i), {31'b0, obs_v[i]}, {31'b0, (q[i].size() > 0)});
         if (q[i].size() > 0) begin
            check($sformatf("i%0d_data", i), obs_d[i], q[i][0][31:0]);
            check($sformatf("i%0d_last", i), {31'b0, obs_l[i]}, {31'b0, q[i][0][32]});
         end else begin
            check($sformatf("i%0d_idle_data", i), obs_d[i], lastval[i]);
            check($sformatf("i%0d_idle_last", i), {31'b0, obs_l[i]}, 32'h0);
         end
      end
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
   task automatic async_rst();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("i%0d_arst_valid", i), {31'b0, obs_v[i]}, 32'h0);
         check($sformatf("i%0d_arst_last", i), {31'b0, obs_l[i]}, 32'h0);
         check($sformatf("i%0d_arst_data", i), obs_d[i], 32'h0);
         q[i].delete();
         lastval[i] = '0;
      end
      step();
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++)
         check($sformatf("i%0d_rel_ready", i), {31'b0, obs_cr[i]}, 32'h1);
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) begin
         cv[i]   = 1'b0;
         ordy[i] = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < N; i++) begin
         ntok[i]    = 0;
         lastval[i] = '0;
      end
      idle_all();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // Streaming, REPEAT=1: one token per cycle, last on every token.
      cv[0] = 1'b1; ordy[0] = 1'b1;
      repeat (8) step();
      cv[0] = 1'b0;
      step();
      check("stream_tokens", ntok[0], 8);
      step();
      idle_all();

      // Single trigger, REPEAT=4, outs_ready toggling 1,0,1,0,...
      cv[2] = 1'b1;
      step();
      cv[2] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         ordy[2] = (c % 2 == 0);
         step();
      end
      check("bp_tokens", ntok[2], 4);
      idle_all();

      // Two step-feature bursts back to back with wrap at 8 bits.
      cv[1] = 1'b1; ordy[1] = 1'b1;
      repeat (5) step();
      cv[1] = 1'b0;
      repeat (5) step();
      check("step_tokens", ntok[1], 8);
      idle_all();

      // Back-to-back bursts, REPEAT=3: no bubble between bursts.
      cv[3] = 1'b1; ordy[3] = 1'b1;
      repeat (6) step();
      cv[3] = 1'b0;
      repeat (4) step();
      check("b2b_tokens", ntok[3], 6);
      idle_all();

      // Reset in the middle of a 5-token burst.
      cv[4] = 1'b1; ordy[4] = 1'b1;
      step();
      cv[4] = 1'b0;
      step();
      step();
      check("mid_tokens_before_rst", ntok[4], 2);
      async_rst();
      repeat (4) step();
      check("mid_tokens_after_rst", ntok[4], 2);
      cv[4] = 1'b1;
      step();
      cv[4] = 1'b0;
      repeat (7) step();
      check("mid_tokens_new_burst", ntok[4], 7);
      idle_all();

      // Randomized traffic on all instances with occasional resets.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            cv[i]   = ($urandom_range(0, 2) == 0);
            ordy[i] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 149) == 0) async_rst();
         else step();
      end
      idle_all();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
